os_rx_multilane_decoder: RTL
============================

Name: os_rx_multilane_decoder

Overview:
- Per-lane ordered-set receive decoder for the PCIe PHY receive path. Sits between the lane deskew/alignment stage and the LTSSM.
- Generalised successor to the single-lane handler:
  - NUM_LANES parallel lanes and a fixed SYMS_PER_CLK datapath.
  - Gen1/2 (8b/10b) and Gen3 (128b/130b) framing.
  - Per-lane TS field capture.
  - Per-lane saturating "consecutive identical TS" counters for LTSSM exit conditions.

Parameters:
- NUM_LANES, 4, number of lanes decoded in parallel (1..16).
- SYMS_PER_CLK, 4, symbols per lane per clock (1, 2 or 4); 16 must be divisible by it.
- CNT_WIDTH, 4, width of each consecutive-TS counter; saturates at 2^CNT_WIDTH-1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- gen3_mode_i  in  1  1 = 128b/130b framing, 0 = 8b/10b; quasi-static, change only while all data_valid_i are low.
- data_i  in  NUM_LANES*SYMS_PER_CLK*8  lane L symbol s at [(L*SYMS_PER_CLK+s)*8 +: 8]; s=0 is first received.
- datak_i  in  NUM_LANES*SYMS_PER_CLK  K-flag per symbol, same indexing (ignored in Gen3).
- sync_header_i  in  NUM_LANES*2  Gen3 sync header; sampled only on a block-start beat.
- block_start_i  in  NUM_LANES  Gen3: beat carries symbol 0 of a block.
- data_valid_i  in  NUM_LANES  per-lane beat valid.
- clear_cnt_i  in  1  zero all consecutive counters.
- ts_valid_o  out  NUM_LANES  1-cycle pulse: a well-formed TS captured.
- ts_type_o  out  NUM_LANES*2  01 TS1, 10 TS2; held.
- link_num_o, lane_num_o, nfts_o, rate_id_o, train_ctrl_o  out  NUM_LANES*8 each  symbols 1..5 of the last good TS; held.
- ts1_cnt_o, ts2_cnt_o  out  NUM_LANES*CNT_WIDTH  consecutive identical TS1/TS2 count.
- eios_o, eieos_o  out  NUM_LANES  1-cycle detect pulses.
- os_err_o  out  NUM_LANES  1-cycle pulse: malformed/aborted OS.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; every lane FSM in HUNT; symbol counters 0.
- Per-lane FSM states: HUNT, COLLECT_TS, COLLECT_EIE, SKIP. The per-lane symbol index sym_idx runs 0..15.
- Gen1/2 OS start: K28.5 (0xBC, K=1) at s=0 of a valid beat. Upstream guarantees COM alignment to s=0.
- Gen1/2 classification is by symbol 1:
  - D-char → COLLECT_TS.
  - K28.7 (0xFC) → COLLECT_EIE.
  - K28.3 (0x7C) → EIOS candidate.
  - K28.0 (0x1C) → SKIP: drop until the next COM.
  - Anything else → HUNT.
- Gen1/2 EIOS: COM + three K28.3 → eios_o.
- Gen1/2 EIEOS: COM + 14×K28.7 + D10.2 (0x4A) → eieos_o.
- Gen1/2 TS: symbols 6..15 are all D-chars.
  - All 0x4A → TS1; all 0x45 → TS2.
  - Any mismatch or K-char → os_err_o, no ts_valid_o.
- Gen3 OS start: block_start_i=1 with sync_header 2'b01. Symbol 0 classifies:
  - 0x1E → TS1, 0x2D → TS2 (symbols 6..15 not checked).
  - 0x66 → EIOS.
  - 0x00 → EIEOS, requiring symbols alternating 0x00/0xFF.
  - 0xAA → SKIP until SKP_END (0xE1) plus 3 symbols.
  - Other → HUNT.
- Gen3 sync header 2'b10 or 2'b00/2'b11 at block start → HUNT; os_err_o only for 00/11.
- Latency: ts_valid_o, eios_o, eieos_o, os_err_o assert exactly 1 clock after the beat carrying the final symbol. Captured fields and counters update in that same cycle.
- Consecutive counters, applied on each good TS:
  - If the type equals the previous good TS type and symbols 1..5 are equal, the matching counter increments (saturating).
  - Otherwise the matching counter is set to 1 and the other type's counter is set to 0.
  - os_err_o on a lane zeroes both of that lane's counters.
  - EIEOS and SKP do not affect counters.
  - clear_cnt_i has priority over any update in the same cycle and zeroes all counters.
- Abort rules:
  - data_valid_i low while in COLLECT_* → os_err_o, HUNT.
  - Gen1/2 COM at s=0 while in COLLECT_* with sym_idx<16 → os_err_o for the aborted OS; the new OS starts on the same beat.
- Lanes are fully independent; any combination of lanes may pulse in the same cycle.
- rst_i mid-OS: the partial OS is discarded with no pulses. Counters and fields return to 0.

Test Plan:
- NUM_LANES=4, SYMS_PER_CLK=4, Gen1: lane 2 gets COM,0x01,0x02,0x1F,0x02,0x00,10×0x4A → 1 clock after beat 4: ts_valid_o=0100, ts_type lane2=01, link=0x01, lane=0x02, nfts=0x1F, ts1_cnt lane2=1.
- Eight identical TS2s on all lanes, then one with link_num changed → ts2_cnt reaches 8, then 1. With CNT_WIDTH=3 it saturates at 7.
- Gen1 TS1 with symbol 9 = 0x45 → os_err_o pulse, ts_valid_o stays 0, counters 0. EIOS (COM,7C,7C,7C) → eios_o pulse.
- Gen3: sync 01, symbol 0 = 0x1E TS → ts_valid_o. Block of 0x00/0xFF alternating → eieos_o. 0xAA×8, 0xE1, then 3 symbols → no pulses, next TS decodes.
- clear_cnt_i asserted on the same cycle as a matching TS1 → ts1_cnt=0. data_valid_i dropped at beat 2 → os_err_o.
- rst_i at beat 2 of a TS → no pulses; all outputs 0 the next cycle.

Source files
------------

// File: rtl/os_rx_multilane_decoder.sv
// Per-lane PCIe ordered-set receive decoder (8b/10b and 128b/130b framing).
// Each lane walks its beat symbol by symbol, captures TS fields and keeps
// saturating consecutive-TS counters for the LTSSM.
module os_rx_multilane_decoder #(
   parameter int unsigned NUM_LANES    = 4,
   parameter int unsigned SYMS_PER_CLK = 4,
   parameter int unsigned CNT_WIDTH    = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                gen3_mode_i,
   input  logic [NUM_LANES*SYMS_PER_CLK*8-1:0] data_i,
   input  logic [NUM_LANES*SYMS_PER_CLK-1:0]   datak_i,
   input  logic [NUM_LANES*2-1:0]              sync_header_i,
   input  logic [NUM_LANES-1:0]                block_start_i,
   input  logic [NUM_LANES-1:0]                data_valid_i,
   input  logic                                clear_cnt_i,
   output logic [NUM_LANES-1:0]                ts_valid_o,
   output logic [NUM_LANES*2-1:0]              ts_type_o,
   output logic [NUM_LANES*8-1:0]              link_num_o,
   output logic [NUM_LANES*8-1:0]              lane_num_o,
   output logic [NUM_LANES*8-1:0]              nfts_o,
   output logic [NUM_LANES*8-1:0]              rate_id_o,
   output logic [NUM_LANES*8-1:0]              train_ctrl_o,
   output logic [NUM_LANES*CNT_WIDTH-1:0]      ts1_cnt_o,
   output logic [NUM_LANES*CNT_WIDTH-1:0]      ts2_cnt_o,
   output logic [NUM_LANES-1:0]                eios_o,
   output logic [NUM_LANES-1:0]                eieos_o,
   output logic [NUM_LANES-1:0]                os_err_o
);

   localparam int unsigned SYM_W = 8;

   localparam logic [7:0] K_COM      = 8'hBC;
   localparam logic [7:0] K_EIE      = 8'hFC;
   localparam logic [7:0] K_EIOS     = 8'h7C;
   localparam logic [7:0] K_SKP      = 8'h1C;
   localparam logic [7:0] D_TS1      = 8'h4A;
   localparam logic [7:0] D_TS2      = 8'h45;
   localparam logic [7:0] G3_TS1     = 8'h1E;
   localparam logic [7:0] G3_TS2     = 8'h2D;
   localparam logic [7:0] G3_EIOS    = 8'h66;
   localparam logic [7:0] G3_EIEOS   = 8'h00;
   localparam logic [7:0] G3_SKP     = 8'hAA;
   localparam logic [7:0] G3_SKP_END = 8'hE1;

   typedef enum logic [1:0] {
      S_HUNT        = 2'd0,
      S_COLLECT_TS  = 2'd1,
      S_COLLECT_EIE = 2'd2,
      S_SKIP        = 2'd3
   } state_t;

   for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane

      // lane walker state
      state_t          r_state;
      logic [3:0]      r_idx;
      logic            r_kind;      // COLLECT_EIE: 0 = EIOS, 1 = EIEOS
      logic            r_t2;        // Gen3 TS type from symbol 0
      logic            r_ok1;
      logic            r_ok2;
      logic            r_skp_seen;
      logic [1:0]      r_skp_rem;
      logic [4:0][7:0] r_cap;

      // registered lane outputs
      logic                 r_ts_valid;
      logic                 r_eios;
      logic                 r_eieos;
      logic                 r_err;
      logic [1:0]           r_ts_type;
      logic [4:0][7:0]      r_fields;
      logic [CNT_WIDTH-1:0] r_ts1_cnt;
      logic [CNT_WIDTH-1:0] r_ts2_cnt;

      // next-state and event wires
      state_t               w_state_nxt;
      logic [3:0]           w_idx_nxt;
      logic                 w_kind_nxt;
      logic                 w_t2_nxt;
      logic                 w_ok1_nxt;
      logic                 w_ok2_nxt;
      logic                 w_skp_seen_nxt;
      logic [1:0]           w_skp_rem_nxt;
      logic [4:0][7:0]      w_cap_nxt;
      logic                 w_ev_ts;
      logic                 w_ev_ts2;
      logic                 w_ev_eios;
      logic                 w_ev_eieos;
      logic                 w_ev_err;
      logic [1:0]           w_type_nxt;
      logic [4:0][7:0]      w_fields_nxt;
      logic [CNT_WIDTH-1:0] w_ts1_cnt_nxt;
      logic [CNT_WIDTH-1:0] w_ts2_cnt_nxt;

      // state register: walker position and partial OS contents
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_state    <= S_HUNT;
            r_idx      <= '0;
            r_kind     <= 1'b0;
            r_t2       <= 1'b0;
            r_ok1      <= 1'b0;
            r_ok2      <= 1'b0;
            r_skp_seen <= 1'b0;
            r_skp_rem  <= '0;
            r_cap      <= '0;
         end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_kind     <= w_kind_nxt;
            r_t2       <= w_t2_nxt;
            r_ok1      <= w_ok1_nxt;
            r_ok2      <= w_ok2_nxt;
            r_skp_seen <= w_skp_seen_nxt;
            r_skp_rem  <= w_skp_rem_nxt;
            r_cap      <= w_cap_nxt;
         end
      end

      // next-state: walk the beat's symbols in arrival order
      always_comb begin : p_next
         state_t          st;
         logic [3:0]      idx;
         logic            kind;
         logic            t2;
         logic            ok1;
         logic            ok2;
         logic            seen;
         logic [1:0]      rem;
         logic [4:0][7:0] cap;
         logic [7:0]      sym;
         logic            k;
         logic [2:0]      ci;
         logic [1:0]      hdr;
         logic            e_ts;
         logic            e_ts2;
         logic            e_eios;
         logic            e_eieos;
         logic            e_err;
         st      = r_state;
         idx     = r_idx;
         kind    = r_kind;
         t2      = r_t2;
         ok1     = r_ok1;
         ok2     = r_ok2;
         seen    = r_skp_seen;
         rem     = r_skp_rem;
         cap     = r_cap;
         sym     = '0;
         k       = 1'b0;
         ci      = '0;
         hdr     = sync_header_i[gl*2 +: 2];
         e_ts    = 1'b0;
         e_ts2   = 1'b0;
         e_eios  = 1'b0;
         e_eieos = 1'b0;
         e_err   = 1'b0;
         if (!data_valid_i[gl]) begin
            if (st == S_COLLECT_TS || st == S_COLLECT_EIE) begin
               e_err = 1'b1;
               st    = S_HUNT;
            end
         end else begin
            for (int s = 0; s < int'(SYMS_PER_CLK); s++) begin
               sym = data_i[(gl*SYMS_PER_CLK + s)*SYM_W +: SYM_W];
               k   = datak_i[gl*SYMS_PER_CLK + s] & ~gen3_mode_i;
               if (s == 0 && (gen3_mode_i ? block_start_i[gl] : (k && sym == K_COM))) begin
                  // new OS start; an unfinished collection is reported as aborted
                  if (st == S_COLLECT_TS || st == S_COLLECT_EIE) e_err = 1'b1;
                  idx  = 4'd1;
                  kind = 1'b0;
                  t2   = 1'b0;
                  ok1  = 1'b1;
                  ok2  = 1'b1;
                  seen = 1'b0;
                  rem  = '0;
                  if (!gen3_mode_i) begin
                     st = S_COLLECT_TS;
                  end else if (hdr != 2'b01) begin
                     st = S_HUNT;
                     if (hdr[1] == hdr[0]) e_err = 1'b1;
                  end else begin
                     case (sym)
                        G3_TS1:   st = S_COLLECT_TS;
                        G3_TS2:   begin st = S_COLLECT_TS;  t2   = 1'b1; end
                        G3_EIOS:  st = S_COLLECT_EIE;
                        G3_EIEOS: begin st = S_COLLECT_EIE; kind = 1'b1; end
                        G3_SKP:   st = S_SKIP;
                        default:  st = S_HUNT;
                     endcase
                  end
               end else begin
                  case (st)
                     S_COLLECT_TS: begin
                        if (!gen3_mode_i && idx == 4'd1 && k) begin
                           idx = 4'd2;
                           case (sym)
                              K_EIE:   begin st = S_COLLECT_EIE; kind = 1'b1; end
                              K_EIOS:  begin st = S_COLLECT_EIE; kind = 1'b0; end
                              K_SKP:   st = S_SKIP;
                              default: st = S_HUNT;
                           endcase
                        end else begin
                           if (idx <= 4'd5) begin
                              ci      = 3'(idx - 4'd1);
                              cap[ci] = sym;
                           end else if (!gen3_mode_i) begin
                              if (k || sym != D_TS1) ok1 = 1'b0;
                              if (k || sym != D_TS2) ok2 = 1'b0;
                           end
                           if (idx == 4'd15) begin
                              st = S_HUNT;
                              if (gen3_mode_i) begin
                                 e_ts  = 1'b1;
                                 e_ts2 = t2;
                              end else if (ok1) begin
                                 e_ts  = 1'b1;
                              end else if (ok2) begin
                                 e_ts  = 1'b1;
                                 e_ts2 = 1'b1;
                              end else begin
                                 e_err = 1'b1;
                              end
                           end
                           idx = idx + 4'd1;
                        end
                     end
                     S_COLLECT_EIE: begin
                        if (gen3_mode_i) begin
                           if (kind && sym != (idx[0] ? 8'hFF : 8'h00)) begin
                              e_err = 1'b1;
                              st    = S_HUNT;
                           end else if (idx == 4'd15) begin
                              st      = S_HUNT;
                              e_eieos = kind;
                              e_eios  = ~kind;
                           end
                        end else if (!kind) begin
                           if (!(k && sym == K_EIOS)) begin
                              e_err = 1'b1;
                              st    = S_HUNT;
                           end else if (idx == 4'd3) begin
                              e_eios = 1'b1;
                              st     = S_HUNT;
                           end
                        end else if (idx == 4'd15) begin
                           e_eieos = ~k && sym == D_TS1;
                           e_err   = k || sym != D_TS1;
                           st      = S_HUNT;
                        end else if (!(k && sym == K_EIE)) begin
                           e_err = 1'b1;
                           st    = S_HUNT;
                        end
                        idx = idx + 4'd1;
                     end
                     S_SKIP: begin
                        // Gen1/2 SKP ends only at the next COM; Gen3 at SKP_END + 3
                        if (gen3_mode_i) begin
                           if (!seen) begin
                              if (sym == G3_SKP_END) begin
                                 seen = 1'b1;
                                 rem  = 2'd3;
                              end
                           end else begin
                              if (rem == 2'd1) st = S_HUNT;
                              rem = rem - 2'd1;
                           end
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end
         w_state_nxt    = st;
         w_idx_nxt      = idx;
         w_kind_nxt     = kind;
         w_t2_nxt       = t2;
         w_ok1_nxt      = ok1;
         w_ok2_nxt      = ok2;
         w_skp_seen_nxt = seen;
         w_skp_rem_nxt  = rem;
         w_cap_nxt      = cap;
         w_ev_ts        = e_ts;
         w_ev_ts2       = e_ts2;
         w_ev_eios      = e_eios;
         w_ev_eieos     = e_eieos;
         w_ev_err       = e_err;
      end

      // output logic: field capture and consecutive-TS counter update
      always_comb begin : p_out
         logic [1:0]           new_type;
         logic                 same;
         logic [CNT_WIDTH-1:0] c1;
         logic [CNT_WIDTH-1:0] c2;
         new_type     = w_ev_ts2 ? 2'b10 : 2'b01;
         same         = (new_type == r_ts_type) && (w_cap_nxt == r_fields);
         c1           = r_ts1_cnt;
         c2           = r_ts2_cnt;
         w_type_nxt   = r_ts_type;
         w_fields_nxt = r_fields;
         if (w_ev_err) begin
            c1 = '0;
            c2 = '0;
         end else if (w_ev_ts) begin
            if (w_ev_ts2) begin
               c2 = !same ? CNT_WIDTH'(1) : (&c2 ? c2 : c2 + CNT_WIDTH'(1));
               if (!same) c1 = '0;
            end else begin
               c1 = !same ? CNT_WIDTH'(1) : (&c1 ? c1 : c1 + CNT_WIDTH'(1));
               if (!same) c2 = '0;
            end
            w_type_nxt   = new_type;
            w_fields_nxt = w_cap_nxt;
         end
         if (clear_cnt_i) begin
            c1 = '0;
            c2 = '0;
         end
         w_ts1_cnt_nxt = c1;
         w_ts2_cnt_nxt = c2;
      end

      // output registers
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_ts_valid <= 1'b0;
            r_eios     <= 1'b0;
            r_eieos    <= 1'b0;
            r_err      <= 1'b0;
            r_ts_type  <= '0;
            r_fields   <= '0;
            r_ts1_cnt  <= '0;
            r_ts2_cnt  <= '0;
         end else begin
            r_ts_valid <= w_ev_ts;
            r_eios     <= w_ev_eios;
            r_eieos    <= w_ev_eieos;
            r_err      <= w_ev_err;
            r_ts_type  <= w_type_nxt;
            r_fields   <= w_fields_nxt;
            r_ts1_cnt  <= w_ts1_cnt_nxt;
            r_ts2_cnt  <= w_ts2_cnt_nxt;
         end
      end

      assign ts_valid_o[gl]                     = r_ts_valid;
      assign eios_o[gl]                         = r_eios;
      assign eieos_o[gl]                        = r_eieos;
      assign os_err_o[gl]                       = r_err;
      assign ts_type_o[gl*2 +: 2]               = r_ts_type;
      assign link_num_o[gl*8 +: 8]              = r_fields[0];
      assign lane_num_o[gl*8 +: 8]              = r_fields[1];
      assign nfts_o[gl*8 +: 8]                  = r_fields[2];
      assign rate_id_o[gl*8 +: 8]               = r_fields[3];
      assign train_ctrl_o[gl*8 +: 8]            = r_fields[4];
      assign ts1_cnt_o[gl*CNT_WIDTH +: CNT_WIDTH] = r_ts1_cnt;
      assign ts2_cnt_o[gl*CNT_WIDTH +: CNT_WIDTH] = r_ts2_cnt;
   end

endmodule
